parity_frame_tx: RTL and testbench

PARITY_FRAME_TX -- requirements
Module: parity_frame_tx

---
 rtl/parity_frame_tx.sv | 124 ++++++++++++
 tb/tb_parity_frame_tx.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/parity_frame_tx.sv
// Serial frame transmitter: start bit, 9 data bits LSB first, even parity, stop bit.
//
// state  | meaning
// IDLE   | line high, ready for a word
// START  | start bit (low) for one bit period
// DATA   | shifting out 9 data bits, LSB first
// PARITY | even-parity bit of the captured word
// STOP   | stop bit (high); done on its last cycle
module parity_frame_tx #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [8:0] x,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       tx_out,
  output logic       parity_out,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(CLKS_PER_BIT - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] idx_q, idx_d;
  logic [8:0] shift_q, shift_d;
  logic       parity_q, parity_d;
  logic       bit_end;

  assign bit_end = (cnt_q == CNT_LAST);

  // Next-state logic: bit-period timing, data shifting and word capture.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    case (state_q)
      IDLE: begin
        cnt_d = 8'd0;
        idx_d = 4'd0;
        if (valid_in) begin
          shift_d  = x;
          parity_d = ^x;
          state_d  = START;
        end
      end
      START: begin
        cnt_d = bit_end ? 8'd0 : cnt_q + 8'd1;
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        cnt_d = bit_end ? 8'd0 : cnt_q + 8'd1;
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (idx_q == 4'd8) begin
            idx_d   = 4'd0;
            state_d = PARITY;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      PARITY: begin
        cnt_d = bit_end ? 8'd0 : cnt_q + 8'd1;
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        cnt_d = bit_end ? 8'd0 : cnt_q + 8'd1;
        if (bit_end) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
        idx_d   = 4'd0;
      end
    endcase
  end

  // State register; reset wins over a simultaneous accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      idx_q    <= 4'd0;
      shift_q  <= 9'd0;
      parity_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
    end
  end

  // Line driver and status outputs decoded from the current state.
  always_comb begin
    tx_out = 1'b1;
    case (state_q)
      START:   tx_out = 1'b0;
      DATA:    tx_out = shift_q[0];
      PARITY:  tx_out = parity_q;
      default: tx_out = 1'b1;
    endcase
  end

  assign ready_out  = (state_q == IDLE) && !rst;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == STOP) && bit_end && !rst;
  assign parity_out = parity_q;

endmodule

// File: tb/tb_parity_frame_tx.sv
// Bench for parity_frame_tx: two instances (4 and 1 clocks per bit) checked
// against a scoreboard of expected line bits built from each accepted word.
module tb_parity_frame_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [8:0] x;
  logic       valid4, valid1;
  logic       ready4, tx4, par4, busy4, done4;
  logic       ready1, tx1, par1, busy1, done1;

  int n_chk  = 0;
  int n_pass = 0;

  logic exp_q[$];
  logic exp_par_q[$];

  logic [8:0] WORDS [4] = '{9'b000011000, 9'b000111011, 9'b011011000, 9'b011111011};
  logic       PARS  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  always #5 clk = ~clk;

  parity_frame_tx #(.CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .rst(rst), .x(x), .valid_in(valid4), .ready_out(ready4),
    .tx_out(tx4), .parity_out(par4), .busy(busy4), .done(done4)
  );

  parity_frame_tx #(.CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst(rst), .x(x), .valid_in(valid1), .ready_out(ready1),
    .tx_out(tx1), .parity_out(par1), .busy(busy1), .done(done1)
  );

  function automatic logic obs_tx(input bit sel);    return sel ? tx1    : tx4;    endfunction
  function automatic logic obs_done(input bit sel);  return sel ? done1  : done4;  endfunction
  function automatic logic obs_busy(input bit sel);  return sel ? busy1  : busy4;  endfunction
  function automatic logic obs_ready(input bit sel); return sel ? ready1 : ready4; endfunction
  function automatic logic obs_par(input bit sel);   return sel ? par1   : par4;   endfunction

  task automatic set_valid(input bit sel, input logic v);
    if (sel) valid1 = v;
    else     valid4 = v;
  endtask

  // Present a word in an idle cycle, record its expected frame, take the accept edge.
  task automatic accept(input bit sel, input logic [8:0] w, input logic p, input bit keep);
    x = w;
    set_valid(sel, 1'b1);
    #1;
    n_chk++; if (obs_ready(sel) !== 1'b1) $display("FAIL accept_ready: got %b want 1", obs_ready(sel)); else n_pass++;
    n_chk++; if (obs_tx(sel) !== 1'b1) $display("FAIL idle_tx: got %b want 1", obs_tx(sel)); else n_pass++;
    exp_q.push_back(1'b0);
    for (int i = 0; i < 9; i++) exp_q.push_back(w[i]);
    exp_q.push_back(p);
    exp_q.push_back(1'b1);
    exp_par_q.push_back(p);
    @(posedge clk); #1;
    if (!keep) set_valid(sel, 1'b0);
  endtask

  // Walk one frame cycle by cycle, popping one expected bit per bit period.
  task automatic check_frame(input bit sel, input int cpb, input int disturb);
    logic b, p;
    int   c;
    n_chk++;
    if (exp_par_q.size() == 0) $display("FAIL parity_sb_empty: got none want entry");
    else begin
      p = exp_par_q.pop_front();
      if (obs_par(sel) !== p) $display("FAIL parity_out: got %b want %b", obs_par(sel), p); else n_pass++;
    end
    for (int per = 0; per < 12; per++) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL bit_sb_empty: period %0d got none want entry", per);
        b = 1'b1;
      end else b = exp_q.pop_front();
      for (int k = 0; k < cpb; k++) begin
        c = per * cpb + k + 1;
        if (c == disturb) begin
          x = ~x;
          set_valid(sel, 1'b1);
        end
        if (c == disturb + 1) set_valid(sel, 1'b0);
        n_chk++; if (obs_tx(sel) !== b) $display("FAIL tx_bit: cycle %0d got %b want %b", c, obs_tx(sel), b); else n_pass++;
        n_chk++; if (obs_done(sel) !== (c == 12 * cpb)) $display("FAIL done: cycle %0d got %b want %b", c, obs_done(sel), (c == 12 * cpb)); else n_pass++;
        n_chk++; if (obs_busy(sel) !== 1'b1) $display("FAIL busy: cycle %0d got %b want 1", c, obs_busy(sel)); else n_pass++;
        n_chk++; if (obs_ready(sel) !== 1'b0) $display("FAIL ready_in_frame: cycle %0d got %b want 0", c, obs_ready(sel)); else n_pass++;
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; valid4 = 1'b1; valid1 = 1'b1; x = WORDS[1];
    @(posedge clk); #1;
    n_chk++; if (ready4 !== 1'b0) $display("FAIL rst_ready: got %b want 0", ready4); else n_pass++;
    n_chk++; if (tx4 !== 1'b1) $display("FAIL rst_tx: got %b want 1", tx4); else n_pass++;
    n_chk++; if (busy4 !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy4); else n_pass++;
    n_chk++; if (done4 !== 1'b0) $display("FAIL rst_done: got %b want 0", done4); else n_pass++;
    n_chk++; if (par4 !== 1'b0) $display("FAIL rst_parity: got %b want 0", par4); else n_pass++;
    n_chk++; if (ready1 !== 1'b0) $display("FAIL rst_ready1: got %b want 0", ready1); else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0; valid4 = 1'b0; valid1 = 1'b0;
    #1;
    n_chk++; if (ready4 !== 1'b1) $display("FAIL post_rst_ready: got %b want 1", ready4); else n_pass++;
    n_chk++; if (busy4 !== 1'b0) $display("FAIL rst_discard_busy: got %b want 0", busy4); else n_pass++;
    n_chk++; if (busy1 !== 1'b0) $display("FAIL rst_discard_busy1: got %b want 0", busy1); else n_pass++;
    n_chk++; if (par4 !== 1'b0) $display("FAIL rst_discard_parity: got %b want 0", par4); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_frame_basic();
    accept(1'b0, WORDS[0], PARS[0], 1'b0);
    check_frame(1'b0, 4, 0);
    n_chk++; if (busy4 !== 1'b0) $display("FAIL basic_end_busy: got %b want 0", busy4); else n_pass++;
    n_chk++; if (done4 !== 1'b0) $display("FAIL basic_end_done: got %b want 0", done4); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_parity();
    for (int i = 1; i < 4; i++) begin
      accept(1'b0, WORDS[i], PARS[i], 1'b0);
      check_frame(1'b0, 4, 0);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      accept(1'b0, WORDS[i], PARS[i], i < 3);
      check_frame(1'b0, 4, 0);
    end
    n_chk++; if (busy4 !== 1'b0) $display("FAIL b2b_end_busy: got %b want 0", busy4); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_ignore();
    accept(1'b0, WORDS[1], PARS[1], 1'b0);
    check_frame(1'b0, 4, 15);
    n_chk++; if (busy4 !== 1'b0) $display("FAIL ignore_busy: got %b want 0", busy4); else n_pass++;
    n_chk++; if (par4 !== PARS[1]) $display("FAIL ignore_parity: got %b want %b", par4, PARS[1]); else n_pass++;
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if (busy4 !== 1'b0) $display("FAIL ignore_no_frame: got %b want 0", busy4); else n_pass++;
  endtask

  task automatic test_reset_mid();
    accept(1'b0, WORDS[2], PARS[2], 1'b0);
    repeat (17) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    n_chk++; if (done4 !== 1'b0) $display("FAIL mid_rst_done: got %b want 0", done4); else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    n_chk++; if (tx4 !== 1'b1) $display("FAIL mid_rst_tx: got %b want 1", tx4); else n_pass++;
    n_chk++; if (busy4 !== 1'b0) $display("FAIL mid_rst_busy: got %b want 0", busy4); else n_pass++;
    n_chk++; if (done4 !== 1'b0) $display("FAIL mid_rst_done2: got %b want 0", done4); else n_pass++;
    n_chk++; if (ready4 !== 1'b1) $display("FAIL mid_rst_ready: got %b want 1", ready4); else n_pass++;
    exp_q.delete();
    exp_par_q.delete();
    @(posedge clk); #1;
    accept(1'b0, WORDS[3], PARS[3], 1'b0);
    check_frame(1'b0, 4, 0);
  endtask

  task automatic test_cpb1();
    accept(1'b1, 9'b111111111, 1'b1, 1'b0);
    check_frame(1'b1, 1, 0);
    n_chk++; if (busy1 !== 1'b0) $display("FAIL cpb1_end_busy: got %b want 0", busy1); else n_pass++;
    n_chk++; if (done1 !== 1'b0) $display("FAIL cpb1_end_done: got %b want 0", done1); else n_pass++;
  endtask

  initial begin
    rst = 1'b1; x = 9'd0; valid4 = 1'b0; valid1 = 1'b0;
    test_reset();
    test_frame_basic();
    test_parity();
    test_back_to_back();
    test_ignore();
    test_reset_mid();
    test_cpb1();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
